// File: rtl/led_breather_pkg.sv
// Shared definitions for the LED breathing blocks: FSM state encoding and
// the PWM full-scale derivation reused by other LED/display stages.
package led_breather_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RISE = 2'd1,
      ST_ON   = 2'd2,
      ST_FALL = 2'd3
   } state_e;

   // Full-scale duty for a PWM counter of the given width.
   function automatic int duty_max(input int pwm_bits);
      return (1 << pwm_bits) - 1;
   endfunction

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/led_breather_pwm_gen.sv
// PWM generator: free-running counter over 0..DUTY_MAX-1 and a registered
// unsigned compare against the requested duty.
module pwm_gen
   import led_breather_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [PWM_BITS-1:0] i_duty,
   output logic                o_pwm
);

   localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(duty_max(PWM_BITS) - 1);

   logic [PWM_BITS-1:0] cnt_q;
   logic [PWM_BITS-1:0] cnt_d;
   logic                pwm_q;
   logic                pwm_d;

   // The period is DUTY_MAX, not 2**PWM_BITS, so full duty is continuously on.
   always_comb begin
      cnt_d = cnt_q + PWM_BITS'(1);
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end
      pwm_d = (cnt_q < i_duty);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   assign o_pwm = pwm_q;

endmodule

// File: rtl/led_breather.sv
// Breathing LED stage: turns a 1-bit blink level into a linear PWM duty ramp
// that reverses smoothly from the current duty when the level flips mid-ramp.
module led_breather
   import led_breather_pkg::*;
#(
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_level,
   output logic                o_led,
   output logic [PWM_BITS-1:0] o_duty,
   output logic                o_busy
);

   localparam logic [PWM_BITS-1:0] DUTY_MAX   = PWM_BITS'(duty_max(PWM_BITS));
   localparam int                  PW         = cnt_width(STEP_DIV);
   localparam logic [PW-1:0]       PRESC_LAST = PW'(STEP_DIV - 1);

   logic                level_q;
   state_e              state_q;
   state_e              state_d;
   logic [PWM_BITS-1:0] duty_q;
   logic [PWM_BITS-1:0] duty_d;
   logic [PW-1:0]       presc_q;
   logic [PW-1:0]       presc_d;
   logic                busy_q;
   logic                busy_d;
   logic                step;

   assign step = (presc_q == PRESC_LAST);

   // presc_d defaults to 0: it only counts while a ramp continues without a
   // step, so every state change and every step restarts the interval.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      presc_d = '0;
      unique case (state_q)
         ST_OFF: begin
            if (level_q) begin
               state_d = ST_RISE;
            end
         end
         ST_RISE: begin
            if (!level_q) begin
               state_d = ST_FALL;
            end else if (step) begin
               duty_d = (duty_q == DUTY_MAX) ? DUTY_MAX : duty_q + PWM_BITS'(1);
               if (duty_d == DUTY_MAX) begin
                  state_d = ST_ON;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         ST_ON: begin
            if (!level_q) begin
               state_d = ST_FALL;
            end
         end
         ST_FALL: begin
            if (level_q) begin
               state_d = ST_RISE;
            end else if (step) begin
               duty_d = (duty_q == '0) ? '0 : duty_q - PWM_BITS'(1);
               if (duty_d == '0) begin
                  state_d = ST_OFF;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
      endcase
      busy_d = (state_d == ST_RISE) || (state_d == ST_FALL);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         level_q <= 1'b0;
         state_q <= ST_OFF;
         duty_q  <= '0;
         presc_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         level_q <= i_level;
         state_q <= state_d;
         duty_q  <= duty_d;
         presc_q <= presc_d;
         busy_q  <= busy_d;
      end
   end

   pwm_gen #(
      .PWM_BITS(PWM_BITS)
   ) u_pwm (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_duty (duty_q),
      .o_pwm  (o_led)
   );

   assign o_duty = duty_q;
   assign o_busy = busy_q;

endmodule

// File: tb/tb_led_breather.sv
// Bench for led_breather: ramp/PWM model checked every cycle, plus directed
// scenarios with hand-computed cycle positions and values.
module tb_led_breather;

   localparam int PWM_BITS = 4;
   localparam int STEP_DIV = 2;
   localparam int DMAX     = 15;

   logic                clk = 1'b0;
   logic                rst;
   logic                lvl;
   logic                led;
   logic [PWM_BITS-1:0] duty;
   logic                busy;

   always #5 clk = ~clk;

   led_breather #(
      .PWM_BITS(PWM_BITS),
      .STEP_DIV(STEP_DIV)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .i_level(lvl),
      .o_led  (led),
      .o_duty (duty),
      .o_busy (busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Behavioural model: duty moves toward the level's target one unit every
   // STEP_DIV cycles; LED is a phase-vs-duty test over a period of DMAX.
   int m_lvl, m_duty, m_dir, m_elapsed, m_phase, m_led, m_busy;
   int want, target;
   bit m_rst_edge = 1'b0;
   bit model_on   = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_lvl = 0; m_duty = 0; m_dir = 0; m_elapsed = 0;
         m_phase = 0; m_led = 0; m_busy = 0;
         m_rst_edge = 1'b1;
         model_on = 1'b1;
      end else begin
         m_rst_edge = 1'b0;
         m_led   = (m_phase < m_duty) ? 1 : 0;
         m_phase = (m_phase + 1) % DMAX;
         want    = (m_lvl != 0) ? 1 : -1;
         target  = (m_lvl != 0) ? DMAX : 0;
         if (m_dir != 0 && m_dir != want) begin
            m_dir = want;
            m_elapsed = 0;
         end else if (m_dir == 0) begin
            if (m_duty != target) begin
               m_dir = want;
               m_elapsed = 0;
            end
         end else begin
            m_elapsed++;
            if (m_elapsed == STEP_DIV) begin
               m_elapsed = 0;
               m_duty = m_duty + m_dir;
               if (m_duty > DMAX) m_duty = DMAX;
               if (m_duty < 0) m_duty = 0;
               if (m_duty == target) m_dir = 0;
            end
         end
         m_busy = (m_dir != 0) ? 1 : 0;
         m_lvl  = int'(lvl);
      end
   end

   // Per-cycle compare, duty slew check and PWM window check.
   int hd[$];
   int hl[$];
   int prev_duty;
   bit have_prev = 1'b0;

   always @(negedge clk) begin
      if (model_on) begin
         chk("duty", int'(duty), m_duty);
         chk("busy", int'(busy), m_busy);
         chk("led", int'(led), m_led);
         if (m_rst_edge) begin
            hd.delete();
            hl.delete();
         end else begin
            int d;
            d = int'(duty) - prev_duty;
            if (have_prev) chk("duty_slew", (d >= -1 && d <= 1) ? 1 : 0, 1);
            hd.push_back(int'(duty));
            hl.push_back(int'(led));
            if (hd.size() > 16) begin
               void'(hd.pop_front());
               void'(hl.pop_front());
            end
            if (hd.size() == 16) begin
               bit stable;
               int ones;
               stable = 1'b1;
               ones = 0;
               for (int i = 0; i < 15; i++) begin
                  if (hd[i] != hd[0]) stable = 1'b0;
                  ones += hl[i+1];
               end
               if (stable) chk("pwm_window", ones, hd[0]);
            end
         end
         prev_duty = int'(duty);
         have_prev = 1'b1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int maxd;
      int first;
      logic [3:0] bcnt;

      // Scenario 1: reset then idle low.
      rst = 1'b1;
      lvl = 1'b0;
      tick(3);
      chk("rst_duty", int'(duty), 0);
      chk("rst_led", int'(led), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         cnt += int'(led) + int'(busy) + int'(duty);
      end
      chk("t1_quiet", cnt, 0);

      // Scenario 2: rise to full-on.
      lvl = 1'b1;
      tick(1);
      chk("t2_busy_n1", int'(busy), 0);
      tick(1);
      chk("t2_busy_n2", int'(busy), 1);
      chk("t2_duty_n2", int'(duty), 0);
      tick(2);
      chk("t2_duty_n4", int'(duty), 1);
      tick(27);
      chk("t2_duty_n31", int'(duty), 14);
      chk("t2_busy_n31", int'(busy), 1);
      tick(1);
      chk("t2_duty_n32", int'(duty), 15);
      chk("t2_busy_n32", int'(busy), 0);
      tick(1);
      cnt = 0;
      for (int i = 0; i < 45; i++) begin
         cnt += int'(led);
         tick(1);
      end
      chk("t2_led_on45", cnt, 45);

      // Scenario 3: fall to off.
      lvl = 1'b0;
      tick(2);
      chk("t3_busy_n2", int'(busy), 1);
      chk("t3_duty_n2", int'(duty), 15);
      tick(2);
      chk("t3_duty_n4", int'(duty), 14);
      tick(27);
      chk("t3_duty_n31", int'(duty), 1);
      tick(1);
      chk("t3_duty_n32", int'(duty), 0);
      chk("t3_busy_n32", int'(busy), 0);
      tick(1);
      cnt = 0;
      for (int i = 0; i < 45; i++) begin
         cnt += int'(led);
         tick(1);
      end
      chk("t3_led_off45", cnt, 0);

      // Scenario 4: reversal at duty 7.
      lvl = 1'b1;
      for (int i = 0; i < 100 && int'(duty) != 7; i++) tick(1);
      chk("t4_reach7", int'(duty), 7);
      lvl = 1'b0;
      maxd = 7;
      first = -1;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (int'(duty) > maxd) maxd = int'(duty);
         if (first < 0 && int'(duty) != 7) first = int'(duty);
      end
      chk("t4_max", maxd, 7);
      chk("t4_next", first, 6);
      chk("t4_end", int'(duty), 0);

      // Scenario 5: reset mid-ramp.
      lvl = 1'b1;
      for (int i = 0; i < 100 && int'(duty) != 9; i++) tick(1);
      chk("t5_reach9", int'(duty), 9);
      rst = 1'b1;
      tick(1);
      chk("t5_duty", int'(duty), 0);
      chk("t5_led", int'(led), 0);
      chk("t5_busy", int'(busy), 0);
      rst = 1'b0;
      tick(1);
      chk("t5_busy_r1", int'(busy), 0);
      tick(1);
      chk("t5_busy_r2", int'(busy), 1);
      chk("t5_duty_r2", int'(duty), 0);
      tick(2);
      chk("t5_duty_r4", int'(duty), 1);

      // Scenario 6: driven by a blinky-style 4-bit counter MSB.
      bcnt = 4'd0;
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         lvl = bcnt[3];
         bcnt = bcnt + 4'd1;
         first = int'(duty);
         tick(1);
         if (int'(duty) != first) cnt++;
      end
      chk("t6_moved", (cnt > 0) ? 1 : 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
